mul_acc_seq: RTL and testbench



---
 rtl/mul_acc_seq.sv | 178 +++++++++++++++++
 tb/tb_mul_acc_seq.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/mul_acc_seq.sv
// mul_acc_seq -- sequential multiply-accumulate execute stage.
//
// Accepts one command (three signed operands, a 3-bit operand select and an
// accumulate flag) over a valid/ready handshake. It forms the selected
// product over two multiply cycles and folds it into an internal
// accumulator. The new accumulator value is then returned over a second
// valid/ready handshake. All arithmetic wraps to WIDTH bits.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   in_valid   command valid
//   in_ready   unit can accept a command (IDLE only)
//   a, b, c    signed operands
//   sel        operand select {SC,SB,SA}; 1 = operand takes part in product
//   acc_en     1: acc <= acc + product; 0: acc <= product
//   out_valid  result valid (held until out_ready)
//   out_ready  consumer accepts result
//   out_data   accumulator value after the command
//   busy       high in any state other than IDLE
module mul_acc_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [2:0]       sel,
  input  logic             acc_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    STEP1 = 2'd1,
    STEP2 = 2'd2,
    HOLD  = 2'd3
  } state_e;

  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  // An unselected operand is replaced by the multiplicative identity.
  function automatic logic [WIDTH-1:0] pick_op(input logic use_op,
                                               input logic [WIDTH-1:0] val);
    logic [WIDTH-1:0] r;
    if (use_op) begin
      r = val;
    end else begin
      r = ONE;
    end
    return r;
  endfunction

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] c_q, c_d;
  logic             zero_q, zero_d;     // latched sel == 000
  logic             acc_en_q, acc_en_d;
  logic [WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q, in_ready_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] p2_s;

  // Next-state and datapath logic; every register holds by default.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    c_d         = c_q;
    zero_d      = zero_q;
    acc_en_d    = acc_en_q;
    prod_d      = prod_q;
    acc_d       = acc_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    p2_s        = ZERO;

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          a_d      = pick_op(sel[0], a);
          b_d      = pick_op(sel[1], b);
          c_d      = pick_op(sel[2], c);
          zero_d   = (sel == 3'b000);
          acc_en_d = acc_en;
          state_d  = STEP1;
        end else begin
          state_d  = IDLE;
        end
      end
      STEP1: begin
        // The low WIDTH bits of a product do not depend on signedness,
        // so a WIDTH x WIDTH -> WIDTH multiply gives the wrapped signed result.
        prod_d  = a_q * b_q;
        state_d = STEP2;
      end
      STEP2: begin
        if (zero_q) begin
          p2_s = ZERO;
        end else begin
          p2_s = prod_q * c_q;
        end
        if (acc_en_q) begin
          acc_d = acc_q + p2_s;
        end else begin
          acc_d = p2_s;
        end
        out_data_d  = acc_d;
        out_valid_d = 1'b1;
        state_d     = HOLD;
      end
      HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end else begin
          state_d     = HOLD;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase

    // Handshake flags are registered and follow the next state directly.
    in_ready_d = (state_d == IDLE);
    busy_d     = (state_d != IDLE);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      a_q         <= ZERO;
      b_q         <= ZERO;
      c_q         <= ZERO;
      zero_q      <= 1'b0;
      acc_en_q    <= 1'b0;
      prod_q      <= ZERO;
      acc_q       <= ZERO;
      out_data_q  <= ZERO;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      c_q         <= c_d;
      zero_q      <= zero_d;
      acc_en_q    <= acc_en_d;
      prod_q      <= prod_d;
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_mul_acc_seq.sv
// Self-checking bench for mul_acc_seq: expected accumulator values are pushed
// to a queue at command acceptance and popped at the result handshake.
module tb_mul_acc_seq;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a, b, c;
  logic [2:0]   sel;
  logic         acc_en;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         busy;

  int           n_vec = 0;
  int           n_err = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] acc_m;

  always #5 clk = ~clk;

  mul_acc_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c         (c),
    .sel       (sel),
    .acc_en    (acc_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outs(input string tag);
    check_eq({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check_eq({tag, "_out_data"},  32'(out_data),  32'd0);
    check_eq({tag, "_busy"},      32'(busy),      32'd0);
    check_eq({tag, "_in_ready"},  32'(in_ready),  32'd1);
  endtask

  // Drive one command, accept it on the next edge and push the model result.
  task automatic send(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic [W-1:0] ic,
                      input logic [2:0] isel, input logic iacc);
    logic [W-1:0] ap, bp, cp, p;
    a = ia; b = ib; c = ic; sel = isel; acc_en = iacc; in_valid = 1'b1;
    check_eq("in_ready_idle", 32'(in_ready), 32'd1);
    cyc();
    ap = isel[0] ? ia : 8'd1;
    bp = isel[1] ? ib : 8'd1;
    cp = isel[2] ? ic : 8'd1;
    p  = ap * bp;
    p  = p * cp;
    if (isel == 3'b000) p = 8'd0;
    acc_m = iacc ? (acc_m + p) : p;
    exp_q.push_back(acc_m);
    // Operands may change freely once the command has been taken.
    in_valid = 1'b0;
    a = 8'($urandom); b = 8'($urandom); c = 8'($urandom);
    sel = 3'($urandom); acc_en = 1'($urandom);
    check_eq("busy_step1",     32'(busy),      32'd1);
    check_eq("in_ready_step1", 32'(in_ready),  32'd0);
    check_eq("ov_step1",       32'(out_valid), 32'd0);
  endtask

  // Full command: latency, optional backpressure stall, result handshake.
  task automatic run(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic [W-1:0] ic,
                     input logic [2:0] isel, input logic iacc, input int stall, input int lit);
    int waited;
    send(ia, ib, ic, isel, iacc);
    cyc();
    check_eq("ov_step2",       32'(out_valid), 32'd0);
    check_eq("in_ready_step2", 32'(in_ready),  32'd0);
    cyc();
    check_eq("ov_latency", 32'(out_valid), 32'd1);
    waited = 0;
    while (!out_valid && waited < 8) begin
      cyc();
      waited++;
    end
    if (!out_valid) begin
      check_eq("ov_timeout", 32'(out_valid), 32'd1);
      exp_q.delete();
      return;
    end
    for (int i = 0; i < stall; i++) begin
      in_valid = ~in_valid;
      a = 8'($urandom); b = 8'($urandom); c = 8'($urandom);
      cyc();
      check_eq("ov_hold",       32'(out_valid), 32'd1);
      check_eq("in_ready_hold", 32'(in_ready),  32'd0);
      if (exp_q.size() > 0) check_eq("data_hold", 32'(out_data), 32'(exp_q[0]));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    if (exp_q.size() > 0) begin
      check_eq("sb_data", 32'(out_data), 32'(exp_q.pop_front()));
    end else begin
      check_eq("sb_empty", 32'(exp_q.size()), 32'd1);
    end
    if (lit >= 0) check_eq("plan_data", 32'(out_data), 32'(lit));
    cyc();
    out_ready = 1'b0;
    check_eq("ov_after",       32'(out_valid), 32'd0);
    check_eq("in_ready_after", 32'(in_ready),  32'd1);
    check_eq("busy_after",     32'(busy),      32'd0);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = 8'd0; b = 8'd0; c = 8'd0; sel = 3'd0; acc_en = 1'b0;
    acc_m = 8'd0;
    cyc();
    cyc();
    check_reset_outs("reset");
    reset = 1'b0;
    // Stray out_ready and no in_valid in IDLE: nothing must happen.
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    check_reset_outs("idle");

    run(8'd3,   8'hFC,  8'd0,   3'b011, 1'b0, 0, 8'hF4);
    run(8'd5,   8'd7,   8'd3,   3'b111, 1'b0, 0, 8'h69);
    run(8'd4,   8'd5,   8'd20,  3'b111, 1'b0, 0, 8'h90);
    run(8'd9,   8'd9,   8'd9,   3'b000, 1'b0, 0, 8'h00);
    run(8'h55,  8'h55,  8'hF9,  3'b100, 1'b0, 0, 8'hF9);
    run(8'hFE,  8'h33,  8'hFD,  3'b101, 1'b0, 0, 8'h06);
    run(8'd2,   8'd5,   8'd0,   3'b011, 1'b0, 0, 10);
    run(8'd20,  8'd0,   8'd0,   3'b001, 1'b1, 0, 30);
    run(8'd127, 8'd0,   8'd0,   3'b001, 1'b1, 5, 8'h9D);

    // Reset while in STEP1 discards the command.
    run(8'd30, 8'd0, 8'd0, 3'b001, 1'b0, 0, 30);
    send(8'd1, 8'd0, 8'd0, 3'b001, 1'b1);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    exp_q.delete();
    acc_m = 8'd0;
    check_reset_outs("rst_step1");
    cyc();
    cyc();
    check_reset_outs("rst_step1_quiet");

    // Reset while in HOLD wins over a simultaneous out handshake.
    run(8'd30, 8'd0, 8'd0, 3'b001, 1'b0, 0, 30);
    send(8'd1, 8'd0, 8'd0, 3'b001, 1'b1);
    cyc();
    cyc();
    check_eq("ov_pre_rst", 32'(out_valid), 32'd1);
    reset = 1'b1;
    out_ready = 1'b1;
    cyc();
    reset = 1'b0;
    out_ready = 1'b0;
    exp_q.delete();
    acc_m = 8'd0;
    check_reset_outs("rst_hold");
    run(8'd1, 8'd0, 8'd0, 3'b001, 1'b1, 0, 8'h01);

    check_eq("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule
